// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage for a single-issue RV32I hart. Owns the PC, issues
//   word reads to a synchronous instruction memory (1-cycle read latency) and
//   presents {instruction, pc, pc+4, valid} to decode. A one-entry skid
//   register catches the word that returns while decode is stalled, so no
//   instruction is lost and the stage sustains one instruction per cycle.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   o_imem_ren         read request this cycle
//   o_imem_raddr       word-aligned byte address of the request
//   i_imem_rdata       read data, valid the cycle after an issued request
//   i_stall            decode cannot accept o_inst (ignored while !o_valid)
//   i_redirect         flush everything and refetch from i_redirect_pc
//   i_redirect_pc      redirect target (low two bits ignored)
//   o_valid            o_inst / o_pc hold a live instruction
//   o_inst, o_pc       fetched word and its address
//   o_pc_plus4         o_pc + 4 (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;

    logic advance;
    logic issue;

    always_comb begin
        // Decode takes the current output (or there is none to take).
        advance      = !valid_q || !i_stall;
        issue        = advance && !i_redirect && !i_rst;
        o_imem_ren   = issue;
        o_imem_raddr = pc_q;

        pc_d         = pc_q;
        pend_d       = 1'b0;
        pend_pc_d    = pend_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q;
        inst_d       = inst_q;
        opc_d        = opc_q;

        if (i_redirect) begin
            // Flush: the word returning this cycle is simply not captured.
            pc_d         = {i_redirect_pc[31:2], 2'b00};
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue) begin
                pend_d    = 1'b1;
                pend_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end

            if (advance) begin
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    inst_d       = skid_inst_q;
                    opc_d        = skid_pc_q;
                    skid_valid_d = 1'b0;
                    // Returning word refills the skid as it drains.
                    if (pend_q) begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = i_imem_rdata;
                        skid_pc_d    = pend_pc_q;
                    end
                end else if (pend_q) begin
                    valid_d = 1'b1;
                    inst_d  = i_imem_rdata;
                    opc_d   = pend_pc_q;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (pend_q) begin
                // Stalled: park the single in-flight word.
                skid_valid_d = 1'b1;
                skid_inst_d  = i_imem_rdata;
                skid_pc_d    = pend_pc_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= {RESET_ADDR[31:2], 2'b00};
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'd0;
            skid_pc_q    <= 32'd0;
            valid_q      <= 1'b0;
            inst_q       <= 32'd0;
            opc_q        <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            opc_q        <= opc_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_inst     = inst_q;
    assign o_pc       = opc_q;
    assign o_pc_plus4 = opc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. The instruction memory model returns
//   word (addr >> 2) one cycle after a request, and a poison value otherwise.
//   Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_ren;
    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_imem_ren   (o_imem_ren),
        .o_imem_raddr (o_imem_raddr),
        .i_imem_rdata (i_imem_rdata),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_valid      (o_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous instruction memory: word[i] = i.
    always @(posedge i_clk) begin
        if (o_imem_ren) i_imem_rdata <= o_imem_raddr >> 2;
        else            i_imem_rdata <= 32'hDEAD_BEEF;
    end

    // Skid must never be written while already full without draining.
    always @(negedge i_clk) begin
        if (!i_rst && !i_redirect && dut.skid_valid_q && dut.pend_q
            && o_valid && i_stall) begin
            n_fail++;
            $display("FAIL skid_overflow: skid full and word arriving under stall at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] rpc);
        i_rst         = rst;
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_pc"}, o_pc, pc);
        check({tag, "_inst"}, o_inst, inst);
        check({tag, "_pc4"}, o_pc_plus4, pc + 32'd4);
    endtask

    // Idle cycles until o_valid, with a bound; inputs are idle (no stall).
    task automatic wait_valid(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (!o_valid && k < max_cycles) begin
            next_cycle();
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            k++;
        end
        n_cmp++;
        if (!o_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: o_valid=0 after %0d cycles, expected 1", tag, max_cycles);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] raddr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    localparam int NVec = 14;
    vec_t tbl [NVec];

    initial begin
        // rst stall redir rpc | ren raddr valid pc inst
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4,   32'h1};
        // stall three cycles holding pc=8
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8,   32'h2};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8,   32'h2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8,   32'h2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8,   32'h2};
        // redirect while 0x10 is in flight
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h14,  1'b1, 32'hC,   32'h3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   32'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 32'h40};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 32'h41};

        drive(1'b1, 1'b0, 1'b0, 32'd0);
        next_cycle();

        for (int i = 0; i < NVec; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            check($sformatf("v%0d_ren", i), {31'd0, o_imem_ren}, {31'd0, tbl[i].ren});
            check($sformatf("v%0d_raddr", i), o_imem_raddr, tbl[i].raddr);
            check($sformatf("v%0d_valid", i), {31'd0, o_valid}, {31'd0, tbl[i].valid});
            if (tbl[i].valid || tbl[i].rst) begin
                check($sformatf("v%0d_pc", i), o_pc, tbl[i].pc);
                check($sformatf("v%0d_inst", i), o_inst, tbl[i].inst);
                check($sformatf("v%0d_pc4", i), o_pc_plus4, tbl[i].pc + 32'd4);
            end
            next_cycle();
        end

        // Redirect to 0x203 together with stall while the skid is full.
        drive(1'b0, 1'b1, 1'b0, 32'd0);              // output 0x108, 0x10C lands in skid
        check_out("rs_hold", 32'h108, 32'h42);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, 32'h203);
        check("rs_ren_redir", {31'd0, o_imem_ren}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("rs_valid_after", {31'd0, o_valid}, 32'd0);
        check("rs_ren", {31'd0, o_imem_ren}, 32'd1);
        check("rs_raddr", o_imem_raddr, 32'h200);
        wait_valid("rs", 4);
        check_out("rs_first", 32'h200, 32'h80);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("rs_second", 32'h204, 32'h81);

        // Reset mid-stream with the skid full.
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd0);              // fill skid
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        check("rst_ren", {31'd0, o_imem_ren}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ren_after", {31'd0, o_imem_ren}, 32'd1);
        check("rst_raddr", o_imem_raddr, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("rst_bubble", {31'd0, o_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("rst_first", 32'h0, 32'h0);

        // PC wrap at 2^32.
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_raddr0", o_imem_raddr, 32'hFFFF_FFFC);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_raddr1", o_imem_raddr, 32'h0);
        wait_valid("wrap", 4);
        check_out("wrap_top", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        check("wrap_pc4_zero", o_pc_plus4, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("wrap_zero", 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
